// File: rtl/gelato_issue_scheduler.sv
// gelato_issue_scheduler: per-cycle warp issue scheduler.
// Tracks in-flight destination registers per warp in small scoreboard tables,
// blocks RAW/WAW hazards, picks a hazard-free warp round-robin and drives a
// single registered issue slot with a valid/ready handshake.
module gelato_issue_scheduler #(
  parameter int WARP_NUM = 4,
  parameter int SB_SIZE  = 4,
  parameter int REG_W    = 5,
  localparam int WID     = $clog2(WARP_NUM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic [WARP_NUM-1:0]       inst_valid,
  input  logic [WARP_NUM*REG_W-1:0] inst_rs1,
  input  logic [WARP_NUM*REG_W-1:0] inst_rs2,
  input  logic [WARP_NUM*REG_W-1:0] inst_rd,
  output logic [WARP_NUM-1:0]       inst_ready,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [WID-1:0]            issue_warp,
  output logic [REG_W-1:0]          issue_rs1,
  output logic [REG_W-1:0]          issue_rs2,
  output logic [REG_W-1:0]          issue_rd,
  input  logic                      wb_valid,
  input  logic [WID-1:0]            wb_warp,
  input  logic [REG_W-1:0]          wb_rd,
  output logic [WARP_NUM-1:0]       sb_full
);

  // Scoreboard: a zero entry is free, a nonzero entry is a dirty register.
  logic [REG_W-1:0] sb [WARP_NUM][SB_SIZE];

  logic [REG_W-1:0] rs1_w [WARP_NUM];
  logic [REG_W-1:0] rs2_w [WARP_NUM];
  logic [REG_W-1:0] rd_w  [WARP_NUM];

  logic [WARP_NUM-1:0] elig;
  logic                slot_free;
  logic                grant;
  logic [WID-1:0]      grant_warp;
  logic [REG_W-1:0]    grant_rd;
  logic [SB_SIZE-1:0]  alloc_oh;
  logic [WID-1:0]      ptr;

  // Unpack the per-warp register fields.
  for (genvar w = 0; w < WARP_NUM; w++) begin : g_unpack
    assign rs1_w[w] = inst_rs1[w*REG_W +: REG_W];
    assign rs2_w[w] = inst_rs2[w*REG_W +: REG_W];
    assign rd_w[w]  = inst_rd[w*REG_W +: REG_W];
  end

  assign slot_free = !issue_valid || issue_ready;
  assign grant_rd  = rd_w[grant_warp];

  // Hazard check and table-full flags against the registered tables only.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    elig    = '0;
    sb_full = '0;
    for (int w = 0; w < WARP_NUM; w++) begin
      logic hit;
      logic full;
      hit  = 1'b0;
      full = 1'b1;
      for (int e = 0; e < SB_SIZE; e++) begin
        if (sb[w][e] == '0) begin
          full = 1'b0;
        end else if (sb[w][e] == rs1_w[w] || sb[w][e] == rs2_w[w] ||
                     sb[w][e] == rd_w[w]) begin
          hit = 1'b1;
        end
      end
      sb_full[w] = full;
      elig[w]    = inst_valid[w] && !hit && (rd_w[w] == '0 || !full);
    end
  end

  // Round-robin pick: first eligible warp at or above the pointer, with wrap.
  always_comb begin
    grant      = 1'b0;
    grant_warp = '0;
    inst_ready = '0;
    if (rst_n && rdy && slot_free) begin
      for (int i = 0; i < WARP_NUM; i++) begin
        if (!grant && elig[ptr + WID'(i)]) begin
          grant      = 1'b1;
          grant_warp = ptr + WID'(i);
        end
      end
    end
    if (grant) inst_ready[grant_warp] = 1'b1;
  end

  // Lowest-index free entry of the granted warp's table.
  always_comb begin
    logic found;
    found    = 1'b0;
    alloc_oh = '0;
    for (int e = 0; e < SB_SIZE; e++) begin
      if (!found && sb[grant_warp][e] == '0) begin
        found       = 1'b1;
        alloc_oh[e] = 1'b1;
      end
    end
  end

  // Scoreboard update: writeback clears a matching entry, grant allocates a free one.
  // An allocation always targets an entry that is zero now, and a writeback only
  // clears a nonzero one, so the two never collide on the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tables are reset explicitly because a stale dirty entry would block a warp forever.
      for (int w = 0; w < WARP_NUM; w++) begin
        for (int e = 0; e < SB_SIZE; e++) begin
          sb[w][e] <= '0;
        end
      end
    end else begin
      for (int w = 0; w < WARP_NUM; w++) begin
        for (int e = 0; e < SB_SIZE; e++) begin
          if (wb_valid && wb_rd != '0 && WID'(w) == wb_warp && sb[w][e] == wb_rd) begin
            sb[w][e] <= '0;
          end else if (grant && grant_rd != '0 && WID'(w) == grant_warp && alloc_oh[e]) begin
            sb[w][e] <= grant_rd;
          end
        end
      end
    end
  end

  // Issue slot: load on grant, drain on accept, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      issue_warp  <= '0;
      issue_rs1   <= '0;
      issue_rs2   <= '0;
      issue_rd    <= '0;
    end else if (grant) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      issue_valid <= 1'b1;
      issue_warp  <= grant_warp;
      issue_rs1   <= rs1_w[grant_warp];
      issue_rs2   <= rs2_w[grant_warp];
      issue_rd    <= grant_rd;
    end else if (issue_valid && issue_ready) begin
      issue_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves just past the granted warp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= grant_warp + WID'(1);
    end
  end

endmodule

// File: doc/gelato_issue_scheduler.md
Name: gelato_issue_scheduler

Overview:
- Per-cycle warp issue scheduler between the per-warp instruction buffers and the operand-collect/execute stage.
- Owns the per-warp dirty-register scoreboard tables and checks RAW/WAW hazards against them.
- Arbitrates round-robin among hazard-free warps and drives one registered issue slot with a valid/ready handshake.
- Frees scoreboard entries on writeback.

Parameters:
- WARP_NUM, 4, number of warps; must be a power of two, at least 2.
- SB_SIZE, 4, scoreboard entries per warp.
- REG_W, 5, register index width; register 0 is never tracked.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rdy  in  1  global enable; low freezes scheduling
- inst_valid  in  WARP_NUM  warp w has a decoded instruction pending
- inst_rs1  in  WARP_NUM*REG_W  source 1 per warp; warp w uses bits [w*REG_W +: REG_W]
- inst_rs2  in  WARP_NUM*REG_W  source 2 per warp; same packing
- inst_rd  in  WARP_NUM*REG_W  destination per warp; same packing
- inst_ready  out  WARP_NUM  one-hot grant; instruction of warp w consumed this cycle
- issue_valid  out  1  issue slot holds an instruction
- issue_ready  in  1  downstream accepts the issue slot
- issue_warp  out  log2(WARP_NUM)  warp id of the issued instruction
- issue_rs1, issue_rs2, issue_rd  out  REG_W each  registers of the issued instruction
- wb_valid  in  1  writeback completes
- wb_warp  in  log2(WARP_NUM)  writeback warp id
- wb_rd  in  REG_W  writeback destination register
- sb_full  out  WARP_NUM  warp scoreboard has no free entry

Behaviour:
- Reset values:
  - All scoreboard entries = 0 (free).
  - issue_valid = 0; issue_warp, issue_rs1, issue_rs2, issue_rd = 0.
  - Round-robin pointer = 0.
  - inst_ready = 0; sb_full = 0.
- Reset asserted mid-operation discards the issue slot and all scoreboard state immediately.
- Eligibility of warp w; all of the following must hold:
  - inst_valid[w] = 1.
  - rs1 matches no nonzero entry of table w; same for rs2.
  - rd matches no nonzero entry of table w (WAW check).
  - If rd != 0, table w has a free entry.
- Hazard checks use the current registered table. A same-cycle writeback does not unblock a warp until the next cycle; there is no bypass.
- Slot free condition: slot_free = !issue_valid | issue_ready.
- Grant rules:
  - Grant occurs only when rdy = 1 and slot_free = 1.
  - The granted warp is the first eligible warp searching from the pointer upward with wrap (WARP_NUM-1 wraps to 0).
  - inst_ready is combinational and one-hot in the grant cycle; all zero if no grant.
- On grant, at the next clk edge:
  - Issue slot loads warp id, rs1, rs2, rd; issue_valid = 1.
  - Pointer = granted warp + 1 (mod WARP_NUM).
  - If rd != 0, rd is written into the lowest-index free entry of that warp's table.
- Slot handshake:
  - If issue_valid & issue_ready and there is no grant, issue_valid = 0 next cycle.
  - If issue_valid & !issue_ready, all slot fields are held stable.
  - Back-to-back issue gives one instruction per cycle when issue_ready stays high.
- Writeback:
  - wb_valid with wb_rd != 0 clears the entry of table wb_warp equal to wb_rd at the next edge.
  - A writeback with no matching entry, or with wb_rd = 0, is ignored.
  - Writeback is processed even when rdy = 0, so no writeback is lost.
- Simultaneous events:
  - A grant set and a writeback clear in the same warp, on different entries, both take effect.
  - The allocation picks a slot free in the current table. A slot being cleared in the same cycle is not reused until the next cycle.
- rdy = 0:
  - No grant; inst_ready = 0.
  - Pointer, slot and table allocations are frozen.
  - issue_valid stays as is, but the issue_ready handshake still drains the slot.
- sb_full[w] is combinational: all SB_SIZE entries of table w are nonzero.
- Duplicate rd within one table is impossible by construction (WAW check).

Test Plan:
- Reset, then warp 0 with rs1=1, rs2=2, rd=3, issue_ready=1:
  - inst_ready=0001 in the grant cycle.
  - Next cycle issue_valid=1, issue_warp=0, issue_rd=3.
  - Table 0 holds 3.
- RAW stall: warp 0 next instruction has rs1=3 while 3 is dirty:
  - No grant, inst_ready=0000.
  - wb_valid with wb_warp=0, wb_rd=3 at cycle t.
  - Grant at cycle t+1, not at t.
- Round-robin: all 4 warps continuously eligible with rd=0 and issue_ready=1:
  - Grants follow the order 0,1,2,3,0, one per cycle.
- Backpressure: issue_ready=0 for 3 cycles while issue_valid=1:
  - Slot fields stable; inst_ready=0000.
  - The cycle issue_ready rises, the next grant occurs and the new instruction appears the following cycle.
- Full table: warp 1 issues rd=4,5,6,7 (SB_SIZE=4):
  - sb_full=0010; a warp 1 instruction with rd=8 is stalled.
  - A rd=0 instruction in warp 1 with no RAW hazard still issues.
  - wb_rd=5 frees an entry; the rd=8 instruction issues next cycle.
- rdy=0 with pending instructions and a wb for rd=4:
  - No grants; pointer unchanged.
  - The entry for rd=4 is cleared.
- Assert rst_n low mid-burst:
  - issue_valid=0 and all tables empty immediately.
